// File: rtl/packet_buffer_pkg.sv
// packet_buffer_pkg -- shared types and default sizing for the packet buffer.
//   wr_state_e       : write-side frame FSM states (IDLE / FILL / DISCARD)
//   DEF_FRAME_BYTES  : default bytes per frame
//   DEF_DEPTH        : default number of committed frames held
//   DEF_ADDR_W       : default byte-address width
package packet_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  localparam int DEF_FRAME_BYTES = 12;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_ADDR_W      = 4;

endpackage

// File: rtl/packet_buffer_frame_store.sv
// frame_store -- (DEPTH+1) x FRAME_BYTES byte array.
//   clock, reset           : rising-edge clock, sync active-high reset (read register only)
//   wr_en_i/wr_slot_i/wr_idx_i/wr_data_i : single write port
//   rd_slot_i/rd_idx_i     : registered read address
//   rd_zero_i              : force the registered read data to zero this cycle
//   rd_data_o              : registered read data (1-cycle latency)
// The array itself is never reset; only the read register is.
module frame_store #(
  parameter int FRAME_BYTES = 12,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 4,
  parameter int SLOT_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [SLOT_W-1:0] wr_slot_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic [7:0]        wr_data_i,
  input  logic              rd_zero_i,
  input  logic [SLOT_W-1:0] rd_slot_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem_q [DEPTH+1][FRAME_BYTES];
  logic [7:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_slot_i][wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || rd_zero_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_slot_i][rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/packet_buffer.sv
// packet_buffer -- assembles fixed-length frames from a decoded byte stream
// and holds up to DEPTH committed frames for random-access readout.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_byte/in_valid/in_last : incoming byte stream; in_last ends a frame
//   rx_enable           : reception permit; dropping it mid-frame abandons the frame
//   address             : byte index within the head frame
//   pop                 : discard the head frame (ignored when empty)
//   clear_flags         : clear overflow/frame_error (a same-cycle set wins)
//   parallel_out        : registered head-frame byte (0 when empty / out of range)
//   full, empty, count  : committed-frame occupancy
//   overflow, frame_error : sticky status flags
//   dbg_state           : write FSM state (wr_state_e encoding)
// Build option: define PKTBUF_OVERWRITE_EN to make a commit while full evict
// the oldest frame instead of dropping the newest one.
module packet_buffer
  import packet_buffer_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 in_byte,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic                       rx_enable,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       pop,
  input  logic                       clear_flags,
  output logic [7:0]                 parallel_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       frame_error,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int BCNT_W = $clog2(FRAME_BYTES + 1);
  localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]  DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [BCNT_W-1:0] FB_CNT    = BCNT_W'(FRAME_BYTES);
  localparam logic [BCNT_W-1:0] LAST_CNT  = BCNT_W'(FRAME_BYTES - 1);

  wr_state_e         state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;   // bytes already written into the fill slot
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic              ovf_q, ovf_d, ferr_q, ferr_d;

  logic              wr_en, commit, ferr_set, ovf_set, pop_ok, is_full;
  logic              commit_ok, rd_adv, rd_zero;
  logic [ADDR_W-1:0] wr_idx;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Write FSM: frame parsing and byte writes into the fill slot.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    wr_en    = 1'b0;
    wr_idx   = ADDR_W'(bcnt_q);
    commit   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && rx_enable) begin
          wr_en  = 1'b1;
          wr_idx = '0;
          if (in_last) begin
            if (FRAME_BYTES == 1) commit = 1'b1;
            else                  ferr_set = 1'b1;
          end else begin
            state_d = ST_FILL;
            bcnt_d  = BCNT_W'(1);
          end
        end
      end
      ST_FILL: begin
        if (!rx_enable) begin
          state_d = ST_IDLE;               // silent abandon, no error
        end else if (in_valid) begin
          if (bcnt_q == FB_CNT) begin
            // One byte too many: if it also ends the frame we are already
            // resynchronised, otherwise skip to the next in_last.
            ferr_set = 1'b1;
            state_d  = in_last ? ST_IDLE : ST_DISCARD;
          end else begin
            wr_en = 1'b1;
            if (in_last) begin
              state_d = ST_IDLE;
              if (bcnt_q == LAST_CNT) commit = 1'b1;
              else                    ferr_set = 1'b1;
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end
        end
      end
      ST_DISCARD: begin
        if (in_valid && in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy: the fill slot is always the free slot after the newest
  // committed frame, so committed data is never overwritten by filling.
  assign is_full = (count_q == DEPTH_CNT);
  assign pop_ok  = pop && (count_q != '0);
  assign ovf_set = commit && is_full && !pop_ok;

`ifdef PKTBUF_OVERWRITE_EN
  assign commit_ok = commit;
  assign rd_adv    = pop_ok || ovf_set;   // evict the oldest frame
`else
  assign commit_ok = commit && !ovf_set;  // drop the newest frame
  assign rd_adv    = pop_ok;
`endif

  always_comb begin
    wr_ptr_d = commit_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_adv ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (commit_ok && !rd_adv)      count_d = count_q + PTR_W'(1);
    else if (rd_adv && !commit_ok) count_d = count_q - PTR_W'(1);
    ovf_d  = (ovf_q  && !clear_flags) || ovf_set;
    ferr_d = (ferr_q && !clear_flags) || ferr_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  // Extra bit so FRAME_BYTES == 2**ADDR_W compares correctly.
  assign rd_zero = (count_q == '0) ||
                   ({1'b0, address} >= (ADDR_W + 1)'(FRAME_BYTES));

  frame_store #(
    .FRAME_BYTES (FRAME_BYTES),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .SLOT_W      (PTR_W)
  ) u_store (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_slot_i (wr_ptr_q),
    .wr_idx_i  (wr_idx),
    .wr_data_i (in_byte),
    .rd_zero_i (rd_zero),
    .rd_slot_i (rd_ptr_q),
    .rd_idx_i  (address),
    .rd_data_o (parallel_out)
  );

  assign full        = is_full;
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign frame_error = ferr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_packet_buffer.sv
// tb_packet_buffer -- self-checking bench for packet_buffer.
// A frame-level model (queue of committed frames, list of bytes in flight)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_packet_buffer;

  localparam int FB     = 12;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clock, reset;
  logic [7:0]        in_byte;
  logic              in_valid, in_last, rx_enable, pop, clear_flags;
  logic [ADDR_W-1:0] address;
  logic [7:0]        parallel_out;
  logic              full, empty, overflow, frame_error;
  logic [CW-1:0]     count;
  logic [1:0]        dbg_state;

  packet_buffer #(.FRAME_BYTES(FB), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .rx_enable(rx_enable), .address(address), .pop(pop),
    .clear_flags(clear_flags), .parallel_out(parallel_out), .full(full),
    .empty(empty), .count(count), .overflow(overflow),
    .frame_error(frame_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard / model ----------------
  int checks_total  = 0;
  int checks_passed = 0;
  bit chk_en = 1'b0;

  logic [FB*8-1:0] exp_q[$];     // committed frames, head first
  logic [7:0]      cur_q[$];     // bytes of the frame being received
  bit              collecting = 1'b0, dropping = 1'b0;
  bit              m_ovf = 1'b0, m_ferr = 1'b0;
  logic [7:0]      m_pout = 8'h00;
  bit              do_commit, ferr_ev, ovf_ev, pop_now, was_full;
  logic [FB*8-1:0] nf;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else checks_passed++;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete(); cur_q.delete();
      collecting = 1'b0; dropping = 1'b0;
      m_ovf = 1'b0; m_ferr = 1'b0; m_pout = 8'h00;
    end else begin
      do_commit = 1'b0; ferr_ev = 1'b0; ovf_ev = 1'b0;
      // readout from the state before this edge
      if (exp_q.size() == 0 || int'(address) >= FB) m_pout = 8'h00;
      else begin
        nf = exp_q[0];
        m_pout = nf[int'(address)*8 +: 8];
      end
      // frame parsing
      if (collecting && !rx_enable) begin
        collecting = 1'b0;
        cur_q.delete();
      end else if (in_valid) begin
        if (dropping) begin
          if (in_last) dropping = 1'b0;
        end else if (!collecting) begin
          if (rx_enable) begin
            cur_q.delete();
            cur_q.push_back(in_byte);
            if (in_last) begin
              if (FB == 1) do_commit = 1'b1; else ferr_ev = 1'b1;
            end else collecting = 1'b1;
          end
        end else begin
          cur_q.push_back(in_byte);
          if (cur_q.size() > FB) begin
            ferr_ev = 1'b1; collecting = 1'b0; dropping = !in_last;
          end else if (in_last) begin
            collecting = 1'b0;
            if (cur_q.size() == FB) do_commit = 1'b1; else ferr_ev = 1'b1;
          end
        end
      end
      // storage
      pop_now  = pop && (exp_q.size() > 0);
      was_full = (exp_q.size() == DEPTH);
      if (pop_now) void'(exp_q.pop_front());
      if (do_commit) begin
        for (int i = 0; i < FB; i++) nf[i*8 +: 8] = cur_q[i];
        if (was_full && !pop_now) begin
          ovf_ev = 1'b1;
`ifdef PKTBUF_OVERWRITE_EN
          void'(exp_q.pop_front());
          exp_q.push_back(nf);
`endif
        end else exp_q.push_back(nf);
      end
      if (clear_flags) begin m_ovf = 1'b0; m_ferr = 1'b0; end
      if (ovf_ev)  m_ovf  = 1'b1;
      if (ferr_ev) m_ferr = 1'b1;
    end
  end

  // compare process: outputs are stable between rising edges
  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_count",  32'(count),        32'(exp_q.size()));
      check("cmp_empty",  32'(empty),        32'(exp_q.size() == 0));
      check("cmp_full",   32'(full),         32'(exp_q.size() == DEPTH));
      check("cmp_pout",   32'(parallel_out), 32'(m_pout));
      check("cmp_ovf",    32'(overflow),     32'(m_ovf));
      check("cmp_ferr",   32'(frame_error),  32'(m_ferr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0; in_last = 1'b0; pop = 1'b0; clear_flags = 1'b0;
    end
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input bit pop_last);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_byte  = base + 8'(i);
      in_last  = (i == len - 1);
      pop      = pop_last && (i == len - 1);
    end
    idle(1);
  endtask

  task automatic pulse_pop();
    @(negedge clock); pop = 1'b1;
    idle(1);
  endtask

  task automatic pulse_clear();
    @(negedge clock); clear_flags = 1'b1;
    idle(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"},  32'(full),  0);
    check({tag, "_pout"},  32'(parallel_out), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_ferr"},  32'(frame_error), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  task automatic rand_traffic(input int n_frames);
    int len, r;
    for (int f = 0; f < n_frames; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = FB - 1;
      else if (r == 1) len = FB + 1;
      else if (r == 2) len = $urandom_range(1, FB + 4);
      else             len = FB;
      for (int i = 0; i < len + $urandom_range(0, 3); i++) begin
        @(negedge clock);
        pop         = ($urandom_range(0, 5) == 0);
        clear_flags = ($urandom_range(0, 19) == 0);
        address     = ADDR_W'($urandom_range(0, 15));
        rx_enable   = ($urandom_range(0, 59) != 0);
        in_valid    = (i < len);
        in_byte     = 8'($urandom_range(0, 255));
        in_last     = (i == len - 1);
      end
    end
    @(negedge clock);
    rx_enable = 1'b1;
    idle(2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; rx_enable = 1'b1;
    address = '0; pop = 1'b0; clear_flags = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check_reset_values("rst");
    reset = 1'b0;
    idle(1);

    // single good frame, readout, pop
    send_frame(FB, 8'h00, 1'b0);
    check("f0_count", 32'(count), 1);
    check("f0_model_count", 32'(exp_q.size()), 1);
    address = 4'd5;
    @(negedge clock);
    check("f0_byte5", 32'(parallel_out), 32'h05);
    address = 4'd13;
    @(negedge clock);
    check("f0_addr_oor", 32'(parallel_out), 0);
    pulse_pop();
    check("pop_empty", 32'(empty), 1);
    @(negedge clock);
    check("pop_pout", 32'(parallel_out), 0);
    pulse_pop();                         // pop while empty is ignored
    check("pop_empty_ignored", 32'(count), 0);

    // short and long frames
    send_frame(FB - 1, 8'h40, 1'b0);
    check("short_ferr", 32'(frame_error), 1);
    check("short_count", 32'(count), 0);
    pulse_clear();
    check("clear_ferr", 32'(frame_error), 0);
    send_frame(FB + 1, 8'h50, 1'b0);
    check("long_ferr", 32'(frame_error), 1);
    check("long_count", 32'(count), 0);
    send_frame(FB, 8'h60, 1'b0);
    check("good_after_err", 32'(count), 1);
    address = 4'd0;
    @(negedge clock);
    check("good_byte0", 32'(parallel_out), 32'h60);
    pulse_pop(); pulse_clear();

    // five frames into DEPTH=4
    for (int k = 1; k <= 5; k++) send_frame(FB, 8'(k * 16), 1'b0);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 4);
    check("ovf_full", 32'(full), 1);
    address = 4'd0;
    @(negedge clock);
`ifdef PKTBUF_OVERWRITE_EN
    check("ovf_head", 32'(parallel_out), 32'h20);
`else
    check("ovf_head", 32'(parallel_out), 32'h10);
`endif

    // commit coincident with pop at full
    pulse_clear();
    send_frame(FB, 8'h70, 1'b1);
    check("cpop_count", 32'(count), 4);
    check("cpop_ovf", 32'(overflow), 0);
    // rx_enable dropped at byte 6
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_byte = 8'h90 + 8'(i); in_last = 1'b0;
      rx_enable = (i != 5);
    end
    @(negedge clock);
    in_valid = 1'b0; rx_enable = 1'b1;
    idle(1);
    check("rxdrop_count", 32'(count), 4);
    check("rxdrop_ferr", 32'(frame_error), 0);
    check("rxdrop_state", 32'(dbg_state), 0);

    // reset during byte 7
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_byte = 8'hC0 + 8'(i); in_last = 1'b0;
      if (i == 6) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    check_reset_values("midrst");
    send_frame(FB, 8'hA0, 1'b0);
    check("post_rst_count", 32'(count), 1);
    address = 4'd0;
    @(negedge clock);
    check("post_rst_b0", 32'(parallel_out), 32'hA0);
    address = 4'd11;
    @(negedge clock);
    check("post_rst_b11", 32'(parallel_out), 32'hAB);
    address = 4'd12;
    @(negedge clock);
    check("post_rst_b12", 32'(parallel_out), 0);

    // randomized traffic against the model
    rand_traffic(220);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/packet_buffer.md
PACKET_BUFFER -- requirements
Module: packet_buffer

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 12: bytes per frame.
REQ-002 SHALL have parameter DEPTH, default 4: committed frames held, legal range 1..16.
REQ-003 SHALL have parameter ADDR_W, default 4: byte-address width, with 2^ADDR_W >= FRAME_BYTES.
REQ-004 SHALL have port clock  in  1: single clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port in_byte  in  8: decoded byte from the serial decoder.
REQ-007 SHALL have port in_valid  in  1: in_byte is valid this cycle.
REQ-008 SHALL have port in_last  in  1: qualified by in_valid; marks the final byte of a frame.
REQ-009 SHALL have port rx_enable  in  1: microcontroller permit for reception.
REQ-010 SHALL have port address  in  ADDR_W: byte index within the head frame.
REQ-011 SHALL have port pop  in  1: one-cycle strobe that discards the head frame.
REQ-012 SHALL have port clear_flags  in  1: clears the sticky flags.
REQ-013 SHALL have port parallel_out  out  8: registered head-frame byte.
REQ-014 SHALL have ports full/empty  out  1 each: count==DEPTH and count==0 respectively.
REQ-015 SHALL have port count  out  $clog2(DEPTH+1): number of committed frames.
REQ-016 SHALL have ports overflow/frame_error  out  1 each: sticky status flags.

Function
REQ-017 SHALL store frames in DEPTH+1 slots; the fill slot is always the slot after the newest committed frame, so a committed frame is never written.
REQ-018 SHALL implement a write FSM with states IDLE, FILL and DISCARD.
REQ-019 IDLE: when in_valid and rx_enable, SHALL write the byte at index 0 and go to FILL; if (in_last and FRAME_BYTES>1), SHALL set frame_error and stay in IDLE.
REQ-020 FILL: for each in_valid byte, SHALL write it at the next index; on in_last with exactly FRAME_BYTES bytes, SHALL commit and go to IDLE.
REQ-021 FILL: on in_last with fewer bytes, SHALL set frame_error, discard the frame and go to IDLE.
REQ-022 FILL: when byte FRAME_BYTES+1 arrives without in_last, SHALL set frame_error and go to DISCARD.
REQ-023 DISCARD: SHALL ignore bytes until in_valid&&in_last, then go to IDLE.
REQ-024 rx_enable deasserted in FILL SHALL drop the partial frame and return to IDLE without frame_error.
REQ-025 Commit SHALL advance wr_ptr and increment count on the clock edge after the last byte; pointers wrap modulo DEPTH+1.
REQ-026 parallel_out SHALL be registered with 1-cycle latency: the head-slot byte[address], or 0 when empty or address>=FRAME_BYTES.
REQ-027 pop while !empty SHALL advance rd_ptr and decrement count; pop while empty SHALL be ignored.
REQ-028 Commit and pop in the same cycle SHALL advance both pointers with count unchanged.
REQ-029 Full at commit, no pop (macro off): the frame SHALL be dropped and overflow set; count SHALL stay DEPTH.
REQ-030 clear_flags SHALL clear overflow and frame_error; a set event in the same cycle SHALL win.

Reset
REQ-031 reset SHALL force: FSM=IDLE, pointers=0, count=0, parallel_out=0, overflow=0, frame_error=0, empty=1, full=0.
REQ-032 reset mid-frame SHALL abandon the partial frame; slot RAM contents SHALL NOT be reset.

Configuration
REQ-033 With macro PKTBUF_OVERWRITE_EN defined, a commit while full without pop SHALL also advance rd_ptr, so the oldest frame is lost, count stays DEPTH and overflow is set.
REQ-034 Without PKTBUF_OVERWRITE_EN, REQ-029 SHALL apply and the newest frame is lost.

Structure
REQ-035 Package packet_buffer_pkg SHALL hold the FSM state enum and default FRAME_BYTES/DEPTH constants.
REQ-036 Sub-module frame_store SHALL hold the (DEPTH+1)*FRAME_BYTES byte array with one write port and one registered read port.

Verification
REQ-037 Send one 12-byte frame 0x00..0x0B -> count=1; address=5 reads 0x05 one cycle later; pop -> empty=1, parallel_out=0.
REQ-038 Send 11-byte and 13-byte frames -> frame_error=1, count=0; the next good frame commits normally.
REQ-039 Send 5 frames with DEPTH=4, macro off -> overflow=1; the head is frame 1 (byte0=first frame's byte0).
REQ-040 Same stimulus with PKTBUF_OVERWRITE_EN -> overflow=1, count=4, the head is frame 2.
REQ-041 Commit coincident with pop at count=4 -> count=4, no overflow; rx_enable dropped at byte 6 -> no commit, no frame_error.
REQ-042 Assert reset during byte 7 of a frame -> all outputs at reset values; the next full frame commits as frame 0.
